div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Upstream feeder and controller for the 8-bit sequential divider.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Drives the divider's load/start handshake (DataA/DataB, LA, EB, s), waits for Done, captures Q/R, and presents each result on a valid/ready output stream.
- Also handles divide-by-zero and divider hang.

Parameters:
- W, 8, operand/result width; must match the divider.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- TIMEOUT, 64, max cycles s may stay high without Done.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  W  dividend.
- in_b  in  W  divisor.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_q  out  W  quotient.
- out_r  out  W  remainder.
- out_dz  out  1  result was divide-by-zero.
- out_to  out  1  result was a divider timeout.
- div_DataA  out  W  to divider DataA.
- div_DataB  out  W  to divider DataB.
- div_LA  out  1  to divider LA.
- div_EB  out  1  to divider EB.
- div_s  out  1  to divider s.
- div_Done  in  1  from divider Done.
- div_Q  in  W  from divider Q.
- div_R  in  W  from divider R.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high, named Reset; the clock is Clock.
- Reset values:
  - FIFO empty; in_ready=1.
  - out_valid=0; out_q, out_r, out_dz, out_to all 0.
  - div_LA, div_EB, div_s = 0; div_DataA, div_DataB = 0.
  - FSM in IDLE; timeout counter = 0.
- FIFO:
  - Push when in_valid and in_ready.
  - Pop on the IDLE->SETUP transition.
  - Simultaneous push and pop on a full FIFO is not allowed: in_ready=0 while full, with no bypass.
  - Pointers wrap modulo DEPTH.
- div_DataA/div_DataB are registered from the popped head entry. They hold stable from SETUP until the FSM returns to IDLE.
- FSM states:
  - IDLE: if FIFO non-empty and out_valid=0, pop into the operand register and go to SETUP. Otherwise stay in IDLE.
  - SETUP (1 cycle): operands already on div_DataA/B. If the divisor is 0, go to DZ. Else go to LOAD.
  - LOAD (1 cycle): div_LA=1, div_EB=1, then go to RUN.
  - RUN: div_s=1 and the timeout counter increments each cycle.
    - If div_Done=1: capture div_Q/div_R into the result register, set out_valid=1, dz=0, to=0, and go to DRAIN.
    - If the counter reaches TIMEOUT-1 without Done: set out_q=all-ones, out_r=0, out_to=1, out_valid=1, and go to DRAIN.
  - DRAIN (1 cycle): div_s=0 so the divider returns to its idle state; counter cleared; go to IDLE.
  - DZ (1 cycle): out_q=all-ones, out_r=dividend, out_dz=1, out_valid=1; go to IDLE. The divider is never started.
- Capture timing: Q/R are sampled on the same edge Done is first seen high. div_s deasserts on the following cycle.
- Output handshake:
  - The result transfers when out_valid and out_ready are both high; out_valid clears on that edge.
  - Result fields hold stable while out_valid=1 and out_ready=0.
  - Only one result is in flight; IDLE does not pop while out_valid=1.
- Latency: minimum in->out is 1 (FIFO) + SETUP + LOAD + divider cycles + 1 capture. A divide-by-zero result appears 3 cycles after acceptance into an empty block.
- Reset mid-operation: everything returns to reset values immediately, and div_s drops asynchronously. Queued requests are lost.
- div_Done seen outside RUN is ignored.

Test Plan:
- Reset, then push (a=FF, b=A7) with out_ready=1.
  - Expect div_LA=div_EB=1 for exactly one cycle, then div_s high until Done.
  - Expect out_q=01, out_r=58, dz=0, to=0, out_valid for one cycle.
- Push 4 pairs back-to-back while out_ready=0: (64,07), (0F,03), (00,05), (09,0A).
  - in_ready drops after the 4th push.
  - Then raise out_ready; results arrive in order: (0E,02), (05,00), (00,00), (00,09).
- Push (2A,00) -> out_q=FF, out_r=2A, out_dz=1. div_s and div_LA never assert for that request.
- Divider model that never raises Done -> after TIMEOUT cycles of div_s: out_to=1, out_q=FF, out_r=00, then div_s=0. The next queued request proceeds normally.
- Assert Reset while in RUN -> div_s=0 and out_valid=0 immediately, FIFO empty. A subsequent push of (10,04) yields (04,00).
- Hold out_ready=0 with a result pending for 10 cycles -> out_q/out_r stable, no FIFO pop, divider idle; release -> next request starts.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: request FIFO and load/start controller for an 8-bit
// sequential divider. It also produces results for divide-by-zero and for a
// divider that never raises Done.
module div_sequencer #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dz,
  output logic         out_to,
  output logic [W-1:0] div_DataA,
  output logic [W-1:0] div_DataB,
  output logic         div_LA,
  output logic         div_EB,
  output logic         div_s,
  input  logic         div_Done,
  input  logic [W-1:0] div_Q,
  input  logic [W-1:0] div_R
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DZ    = 3'd5
  } state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [TW-1:0] tcnt;
  state_t        state;
  state_t        state_next;
  logic          push;
  logic          pop;
  logic          empty;
  logic          timeout_hit;

  assign empty       = (count == '0);
  assign push        = in_valid && in_ready;
  assign pop         = (state == IDLE) && !empty && !out_valid;
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers, occupancy and registered not-full flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      in_ready <= (count_next != CW'(DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = SETUP;
      SETUP:   state_next = (div_DataB == '0) ? DZ : LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (div_Done || timeout_hit) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      DZ:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider controls are registered from the next state so each one is high
  // exactly while the FSM sits in the matching state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_LA    <= 1'b0;
      div_EB    <= 1'b0;
      div_s     <= 1'b0;
      div_DataA <= '0;
      div_DataB <= '0;
      tcnt      <= '0;
    end else begin
      div_LA <= (state_next == LOAD);
      div_EB <= (state_next == LOAD);
      div_s  <= (state_next == RUN);
      if (pop) begin
        div_DataA <= mem[rd_ptr].a;
        div_DataB <= mem[rd_ptr].b;
      end
      if (state == RUN)        tcnt <= tcnt + TW'(1);
      else if (state == DRAIN) tcnt <= '0;
    end
  end

  // Result register: filled on Done, on timeout or on divide-by-zero; cleared by handshake
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
      out_to    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == RUN && div_Done) begin
        out_q     <= div_Q;
        out_r     <= div_R;
        out_dz    <= 1'b0;
        out_to    <= 1'b0;
        out_valid <= 1'b1;
      end else if (state == RUN && timeout_hit) begin
        out_q     <= '1;
        out_r     <= '0;
        out_dz    <= 1'b0;
        out_to    <= 1'b1;
        out_valid <= 1'b1;
      end else if (state == DZ) begin
        out_q     <= '1;
        out_r     <= div_DataA;
        out_dz    <= 1'b1;
        out_to    <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: behavioural divider model plus a result scoreboard.
module tb_div_sequencer;

  localparam int unsigned W       = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          DIV_LAT = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic         out_dz;
  logic         out_to;
  logic [W-1:0] div_DataA;
  logic [W-1:0] div_DataB;
  logic         div_LA;
  logic         div_EB;
  logic         div_s;
  logic         div_Done = 1'b0;
  logic [W-1:0] div_Q = '0;
  logic [W-1:0] div_R = '0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         to;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  div_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz),
    .out_to    (out_to),
    .div_DataA (div_DataA),
    .div_DataB (div_DataB),
    .div_LA    (div_LA),
    .div_EB    (div_EB),
    .div_s     (div_s),
    .div_Done  (div_Done),
    .div_Q     (div_Q),
    .div_R     (div_R)
  );

  always #5 Clock = ~Clock;

  // Divider model: loads on LA/EB, raises Done DIV_LAT cycles into s, or never for the hung start
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           dcnt = 0;
  logic         hung = 1'b0;
  int           la_cnt = 0;
  int           hang_idx = -1;

  always @(posedge Clock) begin
    if (div_LA) begin
      m_a    <= div_DataA;
      la_cnt <= la_cnt + 1;
      hung   <= (la_cnt == hang_idx);
    end
    if (div_EB) m_b <= div_DataB;
    if (!div_s) begin
      div_Done <= 1'b0;
      dcnt     <= 0;
    end else if (!div_Done && !hung) begin
      if (dcnt == DIV_LAT - 1) begin
        div_Done <= 1'b1;
        div_Q    <= (m_b != '0) ? m_a / m_b : '1;
        div_R    <= (m_b != '0) ? m_a % m_b : m_a;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  // Scoreboard: every completed output handshake is compared against the oldest expectation
  always @(negedge Clock) begin
    if (!Reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got q=%h r=%h dz=%b to=%b with nothing expected",
                 out_q, out_r, out_dz, out_to);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if ({out_q, out_r, out_dz, out_to} !== e) begin
          errors++;
          $display("FAIL result: got q=%h r=%h dz=%b to=%b expected q=%h r=%h dz=%b to=%b",
                   out_q, out_r, out_dz, out_to, e.q, e.r, e.dz, e.to);
        end
      end
    end
  end

  // Drive one request and record its expected result when it is accepted
  task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic to);
    res_t e;
    int   n;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.to = 1'b0;
    end else if (to) begin
      e.q = '1; e.r = '0; e.dz = 1'b0; e.to = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.to = 1'b0;
    end
    @(negedge Clock);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL push_accept: in_ready=%b expected 1 for a=%h b=%h", in_ready, a, b);
      return;
    end
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({out_valid, out_q, out_r, out_dz, out_to} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b q=%h r=%h dz=%b to=%b expected all 0",
                         out_valid, out_q, out_r, out_dz, out_to);
    end
    checks++;
    if ({div_LA, div_EB, div_s, div_DataA, div_DataB} !== '0) begin
      errors++; $display("FAIL reset_div_ctrl: got LA=%b EB=%b s=%b A=%h B=%h expected all 0",
                         div_LA, div_EB, div_s, div_DataA, div_DataB);
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    int   n;
    logic s_ok;
    @(posedge Clock); #1 out_ready = 1'b1;
    push_req(8'hFF, 8'hA7, 1'b0);
    n = 0;
    @(negedge Clock);
    while (!div_LA && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if ({div_LA, div_EB, div_s} !== 3'b110) begin
      errors++; $display("FAIL load_pulse: got LA/EB/s=%b%b%b expected 110", div_LA, div_EB, div_s);
    end
    @(negedge Clock);
    checks++;
    if ({div_LA, div_EB, div_s} !== 3'b001) begin
      errors++; $display("FAIL load_one_cycle: got LA/EB/s=%b%b%b expected 001", div_LA, div_EB, div_s);
    end
    n    = 0;
    s_ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (div_s !== 1'b1) s_ok = 1'b0;
      @(negedge Clock);
      n++;
    end
    checks++;
    if (!(out_valid === 1'b1 && s_ok)) begin
      errors++; $display("FAIL run_until_done: got out_valid=%b s_held=%b expected 1/1", out_valid, s_ok);
    end
    @(negedge Clock);
    checks++;
    if ({out_valid, div_s} !== 2'b00) begin
      errors++; $display("FAIL valid_one_cycle: got out_valid=%b s=%b expected 0/0", out_valid, div_s);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] as [4] = '{8'h64, 8'h0F, 8'h00, 8'h09};
    logic [W-1:0] bs [4] = '{8'h07, 8'h03, 8'h05, 8'h0A};
    int n;
    @(posedge Clock); #1 out_ready = 1'b0;
    push_req(8'h14, 8'h03, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first_pending: got out_valid=%b expected 1", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d: got in_ready=%b expected 1", i, in_ready);
      end
      push_req(as[i], bs[i], 1'b0);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: got in_ready=%b expected 0", in_ready);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    int n;
    @(negedge Clock);
    q0 = out_q;
    r0 = out_r;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      checks++;
      if ({out_valid, out_q, out_r, div_s, div_LA, in_ready} !== {1'b1, q0, r0, 3'b000}) begin
        errors++; $display("FAIL hold_cycle_%0d: got v=%b q=%h r=%h s=%b LA=%b rdy=%b expected 1 %h %h 0 0 0",
                           i, out_valid, out_q, out_r, div_s, div_LA, in_ready, q0, r0);
      end
    end
    @(posedge Clock); #1 out_ready = 1'b1;
    n = 0;
    while (!div_LA && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (div_LA !== 1'b1) begin
      errors++; $display("FAIL hold_release_start: got LA=%b expected 1", div_LA);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_div_zero();
    push_req(8'h2A, 8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clock);
      checks++;
      if ({div_LA, div_s, out_valid} !== {2'b00, (i == 4)}) begin
        errors++; $display("FAIL dz_cycle_%0d: got LA=%b s=%b out_valid=%b expected 0 0 %b",
                           i, div_LA, div_s, out_valid, (i == 4));
      end
    end
    @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL dz_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    int s_cycles;
    hang_idx = la_cnt;
    push_req(8'h50, 8'h05, 1'b1);
    push_req(8'hC8, 8'h0B, 1'b0);
    n = 0;
    while (!div_s && n < 20) begin
      @(negedge Clock);
      n++;
    end
    s_cycles = 0;
    while (div_s && s_cycles < 200) begin
      @(negedge Clock);
      s_cycles++;
    end
    checks++;
    if (s_cycles != int'(TIMEOUT)) begin
      errors++; $display("FAIL timeout_s_cycles: got %0d expected %0d", s_cycles, TIMEOUT);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    logic idle_ok;
    push_req(8'h30, 8'h05, 1'b0);
    push_req(8'h40, 8'h02, 1'b0);
    n = 0;
    while (!div_s && n < 20) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({div_s, out_valid, in_ready, div_DataA} !== {3'b001, 8'h00}) begin
      errors++; $display("FAIL reset_mid: got s=%b v=%b rdy=%b A=%h expected 0 0 1 00",
                         div_s, out_valid, in_ready, div_DataA);
    end
    exp_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (div_LA || div_s || out_valid) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++; $display("FAIL reset_fifo_empty: got activity after reset expected none");
    end
    push_req(8'h10, 8'h04, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reset_recover: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
